// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-state codes, register/pair enums, opcode
// constants and fetch-state encodings used by fetch_unit, decoder and control.
package cpu_pkg;

    localparam logic [15:0] CTL_RESET  = 16'hff00;
    localparam logic [15:0] CTL_FETCH  = 16'hff01;
    localparam logic [15:0] CTL_DECODE = 16'hff02;
    localparam logic [15:0] CTL_EXEC   = 16'hff03;
    localparam logic [15:0] CTL_HALT   = 16'hffff;

    typedef enum logic [2:0] {
        REG_A, REG_B, REG_C, REG_D, REG_E, REG_H, REG_L
    } reg_t;

    typedef enum logic [1:0] {
        PAIR_BC, PAIR_DE, PAIR_HL, PAIR_SP
    } pair_t;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LD_A_IMM = 8'h3e;
    localparam logic [7:0] OP_JP       = 8'hc3;
    localparam logic [7:0] OP_RST38    = 8'hff;

    typedef enum logic [1:0] {
        FS_IDLE     = 2'd0,
        FS_WAIT_OP  = 2'd1,
        FS_WAIT_IMM = 2'd2,
        FS_FAULT    = 2'd3
    } fetch_state_t;

    function automatic logic is_wait(input fetch_state_t s);
        return (s == FS_WAIT_OP) || (s == FS_WAIT_IMM);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// 16-bit program counter: synchronous load has priority over increment;
// increment wraps 16'hffff -> 16'h0000.
module pc_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst)       q <= RESET_VAL;
        else if (load) q <= load_val;
        else if (inc)  q <= q + 16'd1;
    end

endmodule

// File: rtl/fetch_unit.sv
// Opcode/operand fetch: owns the PC, issues byte reads and holds the opcode
// steady for the decoder. Handshake: mem_rd_req is a level held until the
// cycle mem_rd_ack=1, in which mem_rdata is valid; acks outside WAIT are ignored.
import cpu_pkg::*;

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  TIMEOUT  = 8'd16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_fetch,
    input  logic         cmd_operand,
    input  logic         cmd_load_pc,
    input  logic [15:0]  pc_in,
    output logic [15:0]  mem_addr,
    output logic         mem_rd_req,
    input  logic         mem_rd_ack,
    input  logic [7:0]   mem_rdata,
    output logic [7:0]   opcode,
    output logic         dec_en,
    output logic [7:0]   operand,
    output logic         operand_valid,
    output logic [15:0]  pc,
    output logic         busy,
    output logic         fault,
    output fetch_state_t state_dbg
);

    fetch_state_t state_q, state_d;
    logic [7:0]   tmo_cnt;
    logic         pc_load, pc_inc, clr_dec, take_op, take_imm, go_fault, clr_fault;

    always_comb begin
        state_d   = state_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        clr_dec   = 1'b0;
        take_op   = 1'b0;
        take_imm  = 1'b0;
        go_fault  = 1'b0;
        clr_fault = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (cmd_load_pc) begin
                    pc_load = 1'b1;
                    clr_dec = 1'b1;
                end else if (cmd_fetch) begin
                    state_d = FS_WAIT_OP;
                    clr_dec = 1'b1;
                end else if (cmd_operand) begin
                    state_d = FS_WAIT_IMM;
                end
            end
            FS_WAIT_OP, FS_WAIT_IMM: begin
                // An ack always beats the timeout in the same cycle.
                if (mem_rd_ack) begin
                    pc_inc   = 1'b1;
                    take_op  = (state_q == FS_WAIT_OP);
                    take_imm = (state_q == FS_WAIT_IMM);
                    state_d  = FS_IDLE;
                end else if ((TIMEOUT != 8'd0) && (tmo_cnt == TIMEOUT - 8'd1)) begin
                    go_fault = 1'b1;
                    state_d  = FS_FAULT;
                end
            end
            FS_FAULT: begin
                if (cmd_load_pc) begin
                    pc_load   = 1'b1;
                    clr_dec   = 1'b1;
                    clr_fault = 1'b1;
                    state_d   = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            opcode        <= OP_NOP;
            dec_en        <= 1'b0;
            operand       <= 8'h00;
            operand_valid <= 1'b0;
            mem_rd_req    <= 1'b0;
            fault         <= 1'b0;
            tmo_cnt       <= 8'd0;
        end else begin
            state_q       <= state_d;
            mem_rd_req    <= is_wait(state_d);
            operand_valid <= take_imm;
            if (take_op) begin
                opcode <= mem_rdata;
                dec_en <= 1'b1;
            end else if (clr_dec) begin
                dec_en <= 1'b0;
            end
            if (take_imm) operand <= mem_rdata;
            if (go_fault)       fault <= 1'b1;
            else if (clr_fault) fault <= 1'b0;
            // Counts unacknowledged cycles of the read still in flight.
            if (is_wait(state_q) && is_wait(state_d)) tmo_cnt <= tmo_cnt + 8'd1;
            else                                     tmo_cnt <= 8'd0;
        end
    end

    pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pc_in),
        .inc      (pc_inc),
        .q        (pc)
    );

    assign mem_addr  = pc;
    assign busy      = (state_q != FS_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: drivers push expected completions, a
// monitor pops them when the DUT reports an opcode, operand or fault.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [7:0]  TMO   = 8'd4;
    localparam logic [15:0] RPC   = 16'h0000;
    localparam logic [1:0]  K_OP  = 2'd0;
    localparam logic [1:0]  K_IMM = 2'd1;
    localparam logic [1:0]  K_FLT = 2'd2;
    localparam int          W     = 26;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_fetch = 1'b0, cmd_operand = 1'b0, cmd_load_pc = 1'b0;
    logic [15:0]  pc_in = 16'h0000;
    logic [15:0]  mem_addr;
    logic         mem_rd_req;
    logic         mem_rd_ack = 1'b0;
    logic [7:0]   mem_rdata = 8'h00;
    logic [7:0]   opcode, operand;
    logic         dec_en, operand_valid, busy, fault;
    logic [15:0]  pc;
    fetch_state_t state_dbg;

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_fetch(cmd_fetch), .cmd_operand(cmd_operand),
        .cmd_load_pc(cmd_load_pc), .pc_in(pc_in), .mem_addr(mem_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
        .opcode(opcode), .dec_en(dec_en), .operand(operand),
        .operand_valid(operand_valid), .pc(pc), .busy(busy), .fault(fault),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [15:0]  m_pc = RPC;
    logic [7:0]   m_opcode = 8'h00;
    logic [7:0]   m_operand = 8'h00;
    logic         m_dec_en = 1'b0;
    logic         m_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_opcode = 8'h00; m_operand = 8'h00; m_dec_en = 1'b0; m_fault = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_req"}, 32'(mem_rd_req), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(m_fault));
        check({tag, "_fault"}, 32'(fault), 32'(m_fault));
        check({tag, "_dec_en"}, 32'(dec_en), 32'(m_dec_en));
        check({tag, "_opcode"}, 32'(opcode), 32'(m_opcode));
    endtask

    // ---------------- monitor ----------------
    logic       prev_dec = 1'b0, prev_fault = 1'b0;
    logic [7:0] prev_opcode = 8'h00;

    task automatic pop_check(input logic [1:0] kind, input logic [7:0] data);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h pc %0h, expected nothing", kind, data, pc);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", 32'(kind), 32'(e[25:24]));
            if (kind != K_FLT) check("evt_data", 32'(data), 32'(e[23:16]));
            check("evt_pc", 32'(pc), 32'(e[15:0]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (operand_valid)          pop_check(K_IMM, operand);
            if (dec_en && !prev_dec)    pop_check(K_OP, opcode);
            if (fault && !prev_fault)   pop_check(K_FLT, 8'h00);
            if (dec_en && prev_dec)     check("opcode_stable", 32'(opcode), 32'(prev_opcode));
        end
        prev_dec    = dec_en;
        prev_fault  = fault;
        prev_opcode = opcode;
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_idle_state("reset");
        check("reset_operand", 32'(operand), 32'(0));
        check("reset_opvalid", 32'(operand_valid), 32'(0));
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic with_fetch, input logic with_op);
        cmd_load_pc = 1'b1; pc_in = v; cmd_fetch = with_fetch; cmd_operand = with_op;
        @(negedge clk);
        cmd_load_pc = 1'b0; cmd_fetch = 1'b0; cmd_operand = 1'b0;
        m_pc = v; m_fault = 1'b0; m_dec_en = 1'b0;
        check_idle_state("load");
    endtask

    // k = request cycle (1-based) on which ack arrives; beyond TMO the read times out.
    task automatic issue(input logic is_op, input logic [7:0] d, input int k, input logic poke);
        logic will_fault;
        will_fault = (TMO != 8'd0) && (k > int'(TMO));
        if (will_fault) exp_q.push_back({K_FLT, 8'h00, m_pc});
        else            exp_q.push_back({(is_op ? K_OP : K_IMM), d, m_pc + 16'd1});
        cmd_fetch = is_op; cmd_operand = !is_op;
        @(negedge clk);
        cmd_fetch = 1'b0; cmd_operand = 1'b0;
        for (int c = 1; c <= k; c++) begin
            check("wait_req", 32'(mem_rd_req), 32'(1));
            check("wait_addr", 32'(mem_addr), 32'(m_pc));
            check("wait_busy", 32'(busy), 32'(1));
            if (poke && c == 1) cmd_operand = 1'b1;
            mem_rdata = 8'($urandom);
            if (c == k && !will_fault) begin
                mem_rd_ack = 1'b1;
                mem_rdata  = d;
            end
            @(negedge clk);
            mem_rd_ack = 1'b0; cmd_operand = 1'b0;
            if (will_fault && c == int'(TMO)) break;
        end
        if (is_op) m_dec_en = 1'b0;
        if (will_fault) begin
            m_fault = 1'b1;
        end else begin
            m_pc = m_pc + 16'd1;
            if (is_op) begin m_opcode = d; m_dec_en = 1'b1; end
            else       m_operand = d;
        end
        check_idle_state(is_op ? "fetch" : "oprnd");
        if (!is_op && !will_fault) begin
            check("operand_val", 32'(operand), 32'(m_operand));
            check("opvalid_pulse", 32'(operand_valid), 32'(1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        issue(1'b1, 8'h3e, 3, 1'b0);
        issue(1'b0, 8'h42, 1, 1'b0);
        @(negedge clk);
        check("opvalid_one_cycle", 32'(operand_valid), 32'(0));
        check("opcode_kept", 32'(opcode), 32'(8'h3e));
        check("dec_en_kept", 32'(dec_en), 32'(1));

        do_load(16'hffff, 1'b1, 1'b0);
        @(negedge clk);
        check("prio_no_req", 32'(mem_rd_req), 32'(0));
        issue(1'b1, 8'hc3, 2, 1'b0);
        check("wrap_pc", 32'(pc), 32'(16'h0000));

        issue(1'b1, 8'h11, int'(TMO) + 1, 1'b0);
        cmd_fetch = 1'b1;
        @(negedge clk);
        cmd_fetch = 1'b0; cmd_operand = 1'b1;
        @(negedge clk);
        cmd_operand = 1'b0;
        check("fault_ign_req", 32'(mem_rd_req), 32'(0));
        check("fault_ign_busy", 32'(busy), 32'(1));
        check("fault_sticky", 32'(fault), 32'(1));
        do_load(16'h0038, 1'b0, 1'b0);

        issue(1'b1, 8'haa, int'(TMO), 1'b0);

        cmd_fetch = 1'b1;
        @(negedge clk);
        cmd_fetch = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check("abort_req", 32'(mem_rd_req), 32'(0));
        check("abort_pc", 32'(pc), 32'(RPC));
        check("abort_busy", 32'(busy), 32'(0));
        rst = 1'b0; mem_rd_ack = 1'b1; mem_rdata = 8'h77;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        check_idle_state("late_ack");

        issue(1'b1, 8'h5a, 3, 1'b1);

        for (int t = 0; t < 80; t++) begin
            int r;
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mem_rd_ack = 1'($urandom_range(0, 1));
                mem_rdata  = 8'($urandom);
                @(negedge clk);
                mem_rd_ack = 1'b0;
            end
            if (m_fault) begin
                do_load(16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                r = $urandom_range(0, 9);
                if (r < 2) do_load(16'($urandom), 1'(r == 1), 1'($urandom_range(0, 1)));
                else       issue(1'(r < 7), 8'($urandom), $urandom_range(1, int'(TMO) + 2), 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
